uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer_if.sv | 12 +
 rtl/uart_tx_framer.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_framer_if.sv
// Word handshake between a producer and the UART transmit framer.
// The producer drives tx_valid/tx_data; the framer answers with tx_ready.
interface uart_tx_framer_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// RS-232 transmit framer: start bit, LSB-first payload, optional parity, 1 or 2 stop bits.
// Optional word buffer enabled by defining UART_TX_FIFO_EN.
module uart_tx_framer #(
  parameter int BAUD_DIV   = 10416,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_framer_if.slave   bus,
  output logic              TxD,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("uart_tx_framer: BAUD_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_framer: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_framer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;

  logic                 word_avail;
  logic [DATA_BITS-1:0] word_data;
  logic                 word_take;
  logic                 bit_end;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_framer: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]          wr_q, rd_q;
  logic                 fifo_empty, fifo_full, push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty   = (wr_q == rd_q);
  assign fifo_full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign bus.tx_ready = !rst_n || !fifo_full;
  assign push         = bus.tx_valid && !fifo_full;
  assign word_avail   = !fifo_empty;
  assign word_data    = fifo_mem[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push)      wr_q <= wr_q + 1'b1;
      if (word_take) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_q[AW-1:0]] <= bus.tx_data;
  end
`else
  assign bus.tx_ready = !rst_n || (state_q == S_IDLE);
  assign word_avail   = bus.tx_valid && bus.tx_ready;
  assign word_data    = bus.tx_data;
`endif

  assign word_take = (state_q == S_IDLE) && word_avail;
  assign bit_end   = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    done_d   = 1'b0;

    // Every transition happens on bit_end, so wrapping to 0 also restarts the count on state entry.
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (word_take) begin
          state_d  = S_START;
          shift_d  = word_data;
          parity_d = (^word_data) ^ (PARITY == 1);
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // TxD is registered from the upcoming state so the line changes together with the state.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = parity_q;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
    end
  end

  assign TxD     = txd_q;
  assign tx_busy = (state_q != S_IDLE);
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: three instances at BAUD_DIV=4 (8N1, 7E2, 8O1).
module tb_uart_tx_framer;
  localparam int BD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  uart_tx_framer_if #(.DATA_BITS(8)) if_a ();
  uart_tx_framer_if #(.DATA_BITS(7)) if_b ();
  uart_tx_framer_if #(.DATA_BITS(8)) if_c ();

  logic txd_a, busy_a, done_a;
  logic txd_b, busy_b, done_b;
  logic txd_c, busy_c, done_c;

  uart_tx_framer #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave), .TxD(txd_a), .tx_busy(busy_a), .tx_done(done_a));
  uart_tx_framer #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave), .TxD(txd_b), .tx_busy(busy_b), .tx_done(done_b));
  uart_tx_framer #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.slave), .TxD(txd_c), .tx_busy(busy_c), .tx_done(done_c));

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_txd(int sel);
    case (sel)
      0:       return txd_a;
      1:       return txd_b;
      default: return txd_c;
    endcase
  endfunction

  function automatic logic get_busy(int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic get_done(int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic get_ready(int sel);
    case (sel)
      0:       return if_a.tx_ready;
      1:       return if_b.tx_ready;
      default: return if_c.tx_ready;
    endcase
  endfunction

  task automatic drive(int sel, logic v, logic [7:0] d);
    case (sel)
      0: begin if_a.tx_valid = v; if_a.tx_data = d; end
      1: begin if_b.tx_valid = v; if_b.tx_data = d[6:0]; end
      default: begin if_c.tx_valid = v; if_c.tx_data = d; end
    endcase
  endtask

  // Hand one word over and return on the first START cycle.
  task automatic start_word(int sel, logic [7:0] d, string name);
    drive(sel, 1'b1, d);
    tests++;
    if (get_ready(sel) !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before_handshake: got %b want 1", name, get_ready(sel));
    end
    tick();
    drive(sel, 1'b0, d);
`ifdef UART_TX_FIFO_EN
    tick();
`endif
    $display("[TB] %s: word 0x%h handed to dut %0d", name, d, sel);
  endtask

  // exp[b] is serial bit b (start bit first); entered on the first START cycle.
  task automatic expect_bits(int sel, logic [15:0] exp, int nbits, string name, logic chk_ready_low);
    int dones = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < BD; c++) begin
        if (b != 0 || c != 0) tick();
        tests++;
        if (get_txd(sel) !== exp[b] || get_busy(sel) !== 1'b1) begin
          fails++;
          $display("FAIL %s bit%0d cyc%0d: TxD=%b busy=%b want TxD=%b busy=1",
                   name, b, c, get_txd(sel), get_busy(sel), exp[b]);
        end
        if (get_done(sel) === 1'b1) dones++;
        if (chk_ready_low) begin
          tests++;
          if (get_ready(sel) !== 1'b0) begin
            fails++;
            $display("FAIL %s ready_in_frame bit%0d: got %b want 0", name, b, get_ready(sel));
          end
        end
      end
    end
    tick();
    tests++;
    if (get_done(sel) !== 1'b1 || dones != 0 || get_busy(sel) !== 1'b0 ||
        get_txd(sel) !== 1'b1 || get_ready(sel) !== 1'b1) begin
      fails++;
      $display("FAIL %s frame_end: done=%b early_dones=%0d busy=%b TxD=%b ready=%b want 1/0/0/1/1",
               name, get_done(sel), dones, get_busy(sel), get_txd(sel), get_ready(sel));
    end
    $display("[TB] %s: frame of %0d bits checked", name, nbits);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'h00);
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      tests++;
      if (get_ready(s) !== 1'b1 || get_txd(s) !== 1'b1 || get_busy(s) !== 1'b0 || get_done(s) !== 1'b0) begin
        fails++;
        $display("FAIL reset_state dut%0d: ready=%b TxD=%b busy=%b done=%b want 1/1/0/0",
                 s, get_ready(s), get_txd(s), get_busy(s), get_done(s));
      end
    end
    rst_n = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      tests++;
      if (get_ready(s) !== 1'b1 || get_txd(s) !== 1'b1 || get_busy(s) !== 1'b0) begin
        fails++;
        $display("FAIL after_release dut%0d: ready=%b TxD=%b busy=%b want 1/1/0",
                 s, get_ready(s), get_txd(s), get_busy(s));
      end
    end
    $display("[TB] reset: checked all instances");
  endtask

  task automatic test_frame_8n1();
    start_word(0, 8'h55, "8N1_0x55");
    expect_bits(0, 16'h02AA, 10, "8N1_0x55", 1'b0);
  endtask

  task automatic test_frame_7e2();
    start_word(1, 8'h41, "7E2_0x41");
    expect_bits(1, 16'h0682, 11, "7E2_0x41", 1'b0);
  endtask

  task automatic test_parity_odd();
    start_word(2, 8'h00, "8O1_0x00");
    expect_bits(2, 16'h0600, 11, "8O1_0x00", 1'b0);
    start_word(2, 8'hFF, "8O1_0xFF");
    expect_bits(2, 16'h07FE, 11, "8O1_0xFF", 1'b0);
  endtask

  task automatic test_back_to_back();
    drive(0, 1'b1, 8'hA5);
    tests++;
    if (get_ready(0) !== 1'b1) begin
      fails++;
      $display("FAIL b2b ready_before: got %b want 1", get_ready(0));
    end
    tick();
    // Changing the word mid-frame must not disturb the frame already in flight.
    drive(0, 1'b1, 8'h3C);
    expect_bits(0, 16'h034A, 10, "b2b_first_0xA5", 1'b1);
    tick();
    drive(0, 1'b0, 8'h00);
    expect_bits(0, 16'h0278, 10, "b2b_second_0x3C", 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    start_word(0, 8'hF0, "abort_0xF0");
    repeat (17) tick();
    tests++;
    if (get_txd(0) !== 1'b0 || get_busy(0) !== 1'b1) begin
      fails++;
      $display("FAIL abort data_bit3: TxD=%b busy=%b want 0/1", get_txd(0), get_busy(0));
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if (get_txd(0) !== 1'b1 || get_busy(0) !== 1'b0 || get_done(0) !== 1'b0 || get_ready(0) !== 1'b1) begin
      fails++;
      $display("FAIL abort after_reset: TxD=%b busy=%b done=%b ready=%b want 1/0/0/1",
               get_txd(0), get_busy(0), get_done(0), get_ready(0));
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (get_ready(0) !== 1'b1) begin
      fails++;
      $display("FAIL abort ready_after_release: got %b want 1", get_ready(0));
    end
    for (int i = 0; i < 8; i++) begin
      if (get_done(0) !== 1'b0 || get_txd(0) !== 1'b1) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL abort quiet_line: %0d bad cycles, want 0", bad);
    end
    start_word(0, 8'hF0, "after_abort_0xF0");
    expect_bits(0, 16'h03E0, 10, "after_abort_0xF0", 1'b0);
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo();
    logic [7:0] words [5];
    words = '{8'h11, 8'h22, 8'h83, 8'hC4, 8'h5A};
    fork
      begin : pusher
        int n = 0;
        int guard = 0;
        while (n < 5 && guard < 100) begin
          drive(0, 1'b1, words[n]);
          if (if_a.tx_ready === 1'b1) n++;
          tick();
          guard++;
        end
        drive(0, 1'b0, 8'h00);
        tests++;
        if (n != 5 || if_a.tx_ready !== 1'b0) begin
          fails++;
          $display("FAIL fifo full_ready: pushed=%0d ready=%b want 5/0", n, if_a.tx_ready);
        end
      end
      begin : decoder
        int got = 0;
        int cyc = 0;
        int pos = 0;
        logic active = 1'b0;
        logic [7:0] w = '0;
        while (got < 5 && cyc < 400) begin
          tick();
          cyc++;
          if (!active && txd_a === 1'b0) begin
            active = 1'b1;
            pos = 0;
          end
          if (active) begin
            for (int k = 0; k < 8; k++) if (pos == 6 + 4 * k) w[k] = txd_a;
            if (pos == 38) begin
              tests++;
              if (w !== words[got] || txd_a !== 1'b1) begin
                fails++;
                $display("FAIL fifo frame%0d: got 0x%h stop=%b want 0x%h stop=1", got, w, txd_a, words[got]);
              end
              $display("[TB] fifo: frame %0d decoded 0x%h", got, w);
              got++;
            end
            if (pos == 39) active = 1'b0;
            pos++;
          end
        end
        tests++;
        if (got != 5) begin
          fails++;
          $display("FAIL fifo frame_count: got %0d want 5", got);
        end
      end
    join
    repeat (4) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_frame_8n1();
    test_frame_7e2();
    test_parity_odd();
`ifdef UART_TX_FIFO_EN
    test_fifo();
`else
    test_back_to_back();
`endif
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
